// File: rtl/mem_map_pkg.sv
// Memory-map constants and in-flight tag types shared by the memory port
// arbiter and the MMU.
package mem_map_pkg;

  localparam logic [31:0] TEXT_BASE = 32'h0000_0000;
  localparam logic [31:0] TEXT_MASK = 32'hF000_0000;
  localparam logic [31:0] DS_BASE   = 32'h1000_0000;
  localparam logic [31:0] DS_MASK   = 32'hF000_0000;
  localparam logic [31:0] IO_BASE   = 32'hFFFF_0000;
  localparam logic [31:0] IO_MASK   = 32'hFFFF_0000;
  localparam logic [31:0] WORD_MASK = 32'h0000_0003;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   is_write;
    logic   err;
  } flight_t;

  function automatic logic in_seg(input logic [31:0] addr,
                                  input logic [31:0] base,
                                  input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the CPU fetch and data ports, the arbiter
// and the single-ported memory.
interface mem_port_arbiter_if #(
  parameter int AW = 32
) ();

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [AW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [AW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [AW-1:0] d_rdata;
  logic          d_err;

  logic [AW-1:0] mem_addr;
  logic [AW-1:0] mem_din;
  logic          mem_we;
  logic [AW-1:0] mem_dout;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_addr, mem_din, mem_we
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_addr, mem_din, mem_we
  );

endinterface

// File: rtl/mem_addr_decode.sv
// Combinational segment and alignment decode of a 32-bit virtual address.
module mem_addr_decode
  import mem_map_pkg::*;
(
  input  logic [31:0] addr,
  output logic        is_text,
  output logic        is_ds,
  output logic        is_io,
  output logic        misaligned
);

  assign is_text    = in_seg(addr, TEXT_BASE, TEXT_MASK);
  assign is_ds      = in_seg(addr, DS_BASE, DS_MASK);
  assign is_io      = in_seg(addr, IO_BASE, IO_MASK);
  assign misaligned = (addr & WORD_MASK) != 32'h0000_0000;

endmodule

// File: rtl/mem_port_arbiter.sv
// Cycle-by-cycle arbiter sharing one memory port between instruction fetch
// and data access, with fixed-latency tagged responses and access screening.
module mem_port_arbiter
  import mem_map_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4,
  parameter int AW         = 32
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0]         starve_cnt_q, starve_cnt_d;
  logic [AW-1:0]         mem_addr_q, mem_addr_d;
  logic [AW-1:0]         mem_din_q, mem_din_d;
  flight_t [MEM_LAT-1:0] flight_q, flight_d;
  flight_t               tail;

  logic if_gnt, d_gnt, if_reject, d_reject;
  logic if_text, if_ds, if_io, if_mis;
  logic d_text, d_ds, d_io, d_mis;
  logic if_dec_unused;
  logic          if_rvalid, d_rvalid, d_err;
  logic [AW-1:0] if_rdata, d_rdata;

  mem_addr_decode u_if_dec (
    .addr       (bus.if_addr),
    .is_text    (if_text),
    .is_ds      (if_ds),
    .is_io      (if_io),
    .misaligned (if_mis)
  );

  mem_addr_decode u_d_dec (
    .addr       (bus.d_addr),
    .is_text    (d_text),
    .is_ds      (d_ds),
    .is_io      (d_io),
    .misaligned (d_mis)
  );

  // Fetch only cares about TEXT; the other segment flags are irrelevant there.
  assign if_dec_unused = if_ds | if_io;
  assign if_reject     = ~if_text | if_mis;
  assign d_reject      = d_mis | ~(d_text | d_ds | d_io);

  // Grant selection: a starved fetch overrides data, otherwise data has priority.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if ((starve_cnt_q == SW'(STARVE_MAX)) && bus.if_req) begin
      if_gnt = 1'b1;
    end else if (bus.d_req) begin
      d_gnt = 1'b1;
    end else if (bus.if_req) begin
      if_gnt = 1'b1;
    end else begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
    end
  end

  // Starvation counter: counts denied fetch cycles, saturating.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.if_req || if_gnt) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q == SW'(STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q;
    end else begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end
  end

  // Memory address/data mux; holds the last value while idle.
  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    if (d_gnt) begin
      mem_addr_d = bus.d_addr;
      mem_din_d  = bus.d_wdata;
    end else if (if_gnt) begin
      mem_addr_d = bus.if_addr;
      mem_din_d  = mem_din_q;
    end else begin
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
    end
  end

  assign bus.if_gnt   = if_gnt;
  assign bus.d_gnt    = d_gnt;
  assign bus.mem_addr = mem_addr_d;
  assign bus.mem_din  = mem_din_d;
  assign bus.mem_we   = d_gnt & bus.d_we & ~d_reject;

  // In-flight tag pipeline: head loaded on grant, tail lines up with mem_dout.
  always_comb begin
    flight_d = '0;
    if (d_gnt) begin
      flight_d[0].valid    = 1'b1;
      flight_d[0].owner    = OWN_D;
      flight_d[0].is_write = bus.d_we;
      flight_d[0].err      = d_reject;
    end else if (if_gnt) begin
      flight_d[0].valid    = 1'b1;
      flight_d[0].owner    = OWN_IF;
      flight_d[0].is_write = 1'b0;
      flight_d[0].err      = if_reject;
    end else begin
      flight_d[0] = '0;
    end
    for (int i = 1; i < MEM_LAT; i++) begin
      flight_d[i] = flight_q[i-1];
    end
  end

  // Response steering from the pipeline tail.
  always_comb begin
    tail      = flight_q[MEM_LAT-1];
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    d_err     = 1'b0;
    if (tail.valid && (tail.owner == OWN_IF)) begin
      if_rvalid = 1'b1;
      if_rdata  = tail.err ? NOP_WORD : bus.mem_dout;
    end else if (tail.valid) begin
      d_rvalid = 1'b1;
      d_err    = tail.err;
      d_rdata  = (tail.err || tail.is_write) ? '0 : bus.mem_dout;
    end else begin
      if_rvalid = 1'b0;
      d_rvalid  = 1'b0;
    end
  end

  assign bus.if_rvalid = if_rvalid;
  assign bus.if_rdata  = if_rdata;
  assign bus.d_rvalid  = d_rvalid;
  assign bus.d_rdata   = d_rdata;
  assign bus.d_err     = d_err;

  // State registers; reset flushes all in-flight responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      flight_q     <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      flight_q     <= flight_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level
// reference model (grant rules, word-addressed memory, expected response queue).
module tb_mem_port_arbiter;

  localparam int MEM_LAT    = 1;
  localparam int STARVE_MAX = 4;

  logic clk;
  logic rst;
  logic env_clr;

  mem_port_arbiter_if #(.AW(32)) bus ();

  mem_port_arbiter #(
    .MEM_LAT    (MEM_LAT),
    .STARVE_MAX (STARVE_MAX),
    .AW         (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memory with MEM_LAT read latency (read-before-write).
  logic [31:0] env_mem [256];
  logic [31:0] dout_pipe [MEM_LAT];

  function automatic logic [7:0] env_idx(input logic [31:0] a);
    return {a[31], a[28], a[7:2]};
  endfunction

  always @(posedge clk) begin
    if (env_clr) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= 32'h0;
    end else if (bus.mem_we) begin
      env_mem[env_idx(bus.mem_addr)] <= bus.mem_din;
    end
    dout_pipe[0] <= env_mem[env_idx(bus.mem_addr)];
    for (int i = 1; i < MEM_LAT; i++) dout_pipe[i] <= dout_pipe[i-1];
  end

  assign bus.mem_dout = dout_pipe[MEM_LAT-1];

  // Reference model state
  typedef struct {
    int          due;
    bit          is_d;
    bit          err;
    logic [31:0] data;
  } rsp_t;

  rsp_t        exp_q [$];
  logic [31:0] ref_mem [logic [31:0]];
  int          m_starve;
  int          cyc;
  bit          g_if, g_d;
  int          n_checks;
  int          n_errors;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic bit mapped(input logic [31:0] a);
    return (a[31:28] == 4'h0) || (a[31:28] == 4'h1) || (a[31:16] == 16'hFFFF);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic check_cycle();
    bit          e_if_gnt, e_d_gnt, e_we, e_ifv, e_dv, e_err, d_rej, if_rej;
    logic [31:0] e_data;
    rsp_t        r;
    e_if_gnt = 1'b0; e_d_gnt = 1'b0; e_ifv = 1'b0; e_dv = 1'b0; e_err = 1'b0;
    e_data   = 32'h0;
    if (m_starve == STARVE_MAX && bus.if_req)  e_if_gnt = 1'b1;
    else if (bus.d_req)                        e_d_gnt  = 1'b1;
    else if (bus.if_req)                       e_if_gnt = 1'b1;
    d_rej  = (bus.d_addr[1:0] != 2'b00) || !mapped(bus.d_addr);
    if_rej = (bus.if_addr[31:28] != 4'h0) || (bus.if_addr[1:0] != 2'b00);
    e_we   = e_d_gnt && bus.d_we && !d_rej;

    chk_eq("if_gnt", 32'(bus.if_gnt), 32'(e_if_gnt));
    chk_eq("d_gnt", 32'(bus.d_gnt), 32'(e_d_gnt));
    chk_eq("gnt_excl", 32'(bus.if_gnt & bus.d_gnt), 32'h0);
    chk_eq("mem_we", 32'(bus.mem_we), 32'(e_we));
    if (e_d_gnt)  chk_eq("mem_addr_d", bus.mem_addr, bus.d_addr);
    if (e_if_gnt) chk_eq("mem_addr_if", bus.mem_addr, bus.if_addr);
    if (e_we)     chk_eq("mem_din", bus.mem_din, bus.d_wdata);

    if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
      r      = exp_q.pop_front();
      e_ifv  = !r.is_d;
      e_dv   = r.is_d;
      e_err  = r.err;
      e_data = r.data;
    end
    chk_eq("if_rvalid", 32'(bus.if_rvalid), 32'(e_ifv));
    chk_eq("d_rvalid", 32'(bus.d_rvalid), 32'(e_dv));
    if (e_ifv) chk_eq("if_rdata", bus.if_rdata, e_data);
    if (e_dv) begin
      chk_eq("d_err", 32'(bus.d_err), 32'(e_err));
      chk_eq("d_rdata", bus.d_rdata, e_data);
    end

    if (e_d_gnt) begin
      r.due  = cyc + MEM_LAT;
      r.is_d = 1'b1;
      r.err  = d_rej;
      r.data = (d_rej || bus.d_we) ? 32'h0 : ref_read(bus.d_addr);
      if (e_we) ref_mem[bus.d_addr] = bus.d_wdata;
      exp_q.push_back(r);
    end else if (e_if_gnt) begin
      r.due  = cyc + MEM_LAT;
      r.is_d = 1'b0;
      r.err  = if_rej;
      r.data = if_rej ? 32'h0 : ref_read(bus.if_addr);
      exp_q.push_back(r);
    end
    if (bus.if_req && !e_if_gnt) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
    else                         m_starve = 0;
    g_if = e_if_gnt;
    g_d  = e_d_gnt;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic data_op(input bit we, input logic [31:0] a, input logic [31:0] wd);
    bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd;
    for (int n = 0; n < 20; n++) begin
      step();
      if (g_d) break;
    end
    bus.d_req = 1'b0;
  endtask

  task automatic fetch_op(input logic [31:0] a);
    bus.if_req = 1'b1; bus.if_addr = a;
    for (int n = 0; n < 20; n++) begin
      step();
      if (g_if) break;
    end
    bus.if_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.if_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    exp_q.delete();
    m_starve = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_if_gnt", 32'(bus.if_gnt), 32'h0);
    chk_eq("rst_d_gnt", 32'(bus.d_gnt), 32'h0);
    chk_eq("rst_if_rvalid", 32'(bus.if_rvalid), 32'h0);
    chk_eq("rst_d_rvalid", 32'(bus.d_rvalid), 32'h0);
    chk_eq("rst_d_err", 32'(bus.d_err), 32'h0);
    chk_eq("rst_if_rdata", bus.if_rdata, 32'h0);
    chk_eq("rst_d_rdata", bus.d_rdata, 32'h0);
    chk_eq("rst_mem_we", 32'(bus.mem_we), 32'h0);
    chk_eq("rst_mem_addr", bus.mem_addr, 32'h0);
    chk_eq("rst_mem_din", bus.mem_din, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] off;
    int          r;
    off = {27'h0, 3'($urandom_range(0, 7)), 2'b00};
    r   = $urandom_range(0, 9);
    if (r <= 2)      return 32'h0000_0000 | off;
    else if (r <= 5) return 32'h1000_0000 | off;
    else if (r <= 7) return 32'hFFFF_0000 | off;
    else if (r == 8) return 32'hFFFF_FFFC;
    else begin
      case ($urandom_range(0, 2))
        0:       return 32'h1000_0000 | off | 32'($urandom_range(1, 3));
        1:       return 32'h2000_0000 | off;
        default: return 32'h8000_0000 | off;
      endcase
    end
  endfunction

  initial begin
    rst = 1'b1; env_clr = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    n_checks = 0; n_errors = 0; cyc = 0; m_starve = 0; g_if = 1'b0; g_d = 1'b0;
    do_reset();
    env_clr = 1'b0;

    // Write then read back in data segment
    data_op(1'b1, 32'h1000_0020, 32'h2222_2222);
    idle(2);
    data_op(1'b0, 32'h1000_0020, 32'h0);
    idle(2);

    // Data write into TEXT, then fetch it
    data_op(1'b1, 32'h0000_0010, 32'h1111_1111);
    fetch_op(32'h0000_0010);
    idle(2);

    // Rejected data accesses
    data_op(1'b1, 32'h1000_0022, 32'hDEAD_BEEF);
    data_op(1'b0, 32'h2000_0000, 32'h0);
    idle(2);

    // IO words including top of address space; screened fetches
    data_op(1'b1, 32'hFFFF_0004, 32'h3333_3333);
    data_op(1'b0, 32'hFFFF_0004, 32'h0);
    data_op(1'b1, 32'hFFFF_FFFC, 32'h4444_4444);
    data_op(1'b0, 32'hFFFF_FFFC, 32'h0);
    fetch_op(32'h1000_0020);
    fetch_op(32'h0000_0012);
    idle(2);

    // Contention: both requesters held, fetch must win every fifth cycle
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0010;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h1000_0020;
    idle(15);
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    idle(3);

    // Reset while responses are in flight
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h1000_0020;
    step();
    bus.d_req = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0010;
    @(negedge clk);
    check_cycle();
    do_reset();
    idle(4);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if (!bus.d_req && $urandom_range(0, 2) != 0) begin
        bus.d_req   = 1'b1;
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_addr  = pick_addr();
        bus.d_wdata = $urandom;
      end
      if (!bus.if_req && $urandom_range(0, 1) != 0) begin
        bus.if_req  = 1'b1;
        bus.if_addr = pick_addr();
      end
      step();
      if (g_d)  bus.d_req  = 1'b0;
      if (g_if) bus.if_req = 1'b0;
    end
    bus.d_req = 1'b0; bus.if_req = 1'b0;
    idle(MEM_LAT + 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
